// File: rtl/mopshub_test_sequencer_if.sv
// Handshake bundle between the MOPSHUB test sequencer and whoever drives it:
// run control and phase-end inputs in, phase strobes and status out.
interface mopshub_test_sequencer_if #(
  parameter int REPEAT_W = 8
);
  logic                start;
  logic                abort;
  logic [3:0]          phase_mask;
  logic [REPEAT_W-1:0] n_repeat;
  logic                trim_done;
  logic                rx_end;
  logic                tx_end;
  logic                custom_end;
  logic                osc_auto_trim;
  logic                test_rx;
  logic                test_tx;
  logic                test_advanced;
  logic                endwait_all;
  logic [2:0]          phase;
  logic [REPEAT_W-1:0] iter_cnt;
  logic                busy;
  logic                done;
  logic                timeout_err;
  logic [2:0]          err_phase;

  modport master (
    output start, abort, phase_mask, n_repeat,
    output trim_done, rx_end, tx_end, custom_end,
    input  osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
    input  phase, iter_cnt, busy, done, timeout_err, err_phase
  );

  modport slave (
    input  start, abort, phase_mask, n_repeat,
    input  trim_done, rx_end, tx_end, custom_end,
    output osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
    output phase, iter_cnt, busy, done, timeout_err, err_phase
  );
endinterface

// File: rtl/mopshub_test_sequencer.sv
// Clocked Moore sequencer for the MOPSHUB system-test phases (trim, RX, gap, TX,
// custom) with phase mask, repeat count, per-phase timeout and abort.
module mopshub_test_sequencer #(
  parameter int GAP_CYCLES     = 120,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int REPEAT_W       = 8
) (
  input logic                     clk_40_m,
  input logic                     rst,
  mopshub_test_sequencer_if.slave seq
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TRIM    = 4'd1,
    S_RX      = 4'd2,
    S_ENDWAIT = 4'd3,
    S_GAP     = 4'd4,
    S_TX      = 4'd5,
    S_CUSTOM  = 4'd6,
    S_NEXT    = 4'd7,
    S_DONE    = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  localparam int TO_W    = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W   = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

  state_t              state_r;
  state_t              state_next;
  logic                start_r;
  logic                start_d_r;
  logic                start_edge_s;
  logic [3:0]          mask_r;
  logic [REPEAT_W-1:0] rep_r;
  logic [REPEAT_W-1:0] iter_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic                to_hit_s;
  logic                gap_hit_s;
  logic                more_s;
  logic                osc_r;
  logic                rx_r;
  logic                tx_r;
  logic                adv_r;
  logic                ew_r;
  logic                busy_r;
  logic                done_r;
  logic                terr_r;
  logic [2:0]          phase_r;
  logic [2:0]          err_phase_r;

  // First enabled waiting phase at or after position 'from' (0 trim .. 3 custom); NEXT if none.
  function automatic state_t first_phase(input logic [3:0] m, input logic [1:0] from);
    return (m[0] && (from == 2'd0)) ? S_TRIM :
           (m[1] && (from <= 2'd1)) ? S_RX   :
           (m[2] && (from <= 2'd2)) ? S_TX   :
           m[3]                     ? S_CUSTOM : S_NEXT;
  endfunction

  function automatic logic [2:0] phase_code(input state_t s);
    logic [2:0] c;
    case (s)
      S_TRIM:            c = 3'd1;
      S_RX:              c = 3'd2;
      S_ENDWAIT, S_GAP:  c = 3'd3;
      S_TX:              c = 3'd4;
      S_CUSTOM:          c = 3'd5;
      S_ERROR:           c = 3'd6;
      default:           c = 3'd0;
    endcase
    return c;
  endfunction

  function automatic logic is_waiting(input state_t s);
    return (s == S_TRIM) || (s == S_RX) || (s == S_TX) || (s == S_CUSTOM);
  endfunction

  assign start_edge_s = start_r & ~start_d_r;
  assign to_hit_s     = (to_cnt_r == TO_LAST);
  assign gap_hit_s    = (gap_cnt_r == GAP_LAST);
  assign more_s       = (({1'b0, iter_r} + (REPEAT_W + 1)'(1)) < {1'b0, rep_r});

  // Next-state decode; an end input is checked before the timeout so it wins a tie.
  always_comb begin
    state_next = state_r;
    if (seq.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!start_edge_s) begin
            state_next = S_IDLE;
          end else if (seq.phase_mask == 4'b0000) begin
            state_next = S_DONE;
          end else begin
            state_next = first_phase(seq.phase_mask, 2'd0);
          end
        end
        S_TRIM: begin
          if (seq.trim_done)  state_next = first_phase(mask_r, 2'd1);
          else if (to_hit_s)  state_next = S_ERROR;
          else                state_next = S_TRIM;
        end
        S_RX: begin
          if (seq.rx_end)     state_next = S_ENDWAIT;
          else if (to_hit_s)  state_next = S_ERROR;
          else                state_next = S_RX;
        end
        S_ENDWAIT:            state_next = S_GAP;
        S_GAP: begin
          if (gap_hit_s)      state_next = first_phase(mask_r, 2'd2);
          else                state_next = S_GAP;
        end
        S_TX: begin
          if (seq.tx_end)     state_next = first_phase(mask_r, 2'd3);
          else if (to_hit_s)  state_next = S_ERROR;
          else                state_next = S_TX;
        end
        S_CUSTOM: begin
          if (seq.custom_end) state_next = S_NEXT;
          else if (to_hit_s)  state_next = S_ERROR;
          else                state_next = S_CUSTOM;
        end
        S_NEXT: begin
          if (more_s)         state_next = first_phase(mask_r, 2'd0);
          else                state_next = S_DONE;
        end
        S_DONE:               state_next = S_IDLE;
        S_ERROR:              state_next = S_ERROR;
        default:              state_next = S_IDLE;
      endcase
    end
  end

  // State register and start-edge pipeline.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      start_r   <= 1'b0;
      start_d_r <= 1'b0;
    end else begin
      state_r   <= state_next;
      start_r   <= seq.start;
      start_d_r <= start_r;
    end
  end

  // Run configuration, iteration count and timeout status.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      mask_r      <= 4'b0000;
      rep_r       <= {REPEAT_W{1'b0}};
      iter_r      <= {REPEAT_W{1'b0}};
      terr_r      <= 1'b0;
      err_phase_r <= 3'd0;
    end else if ((state_r == S_IDLE) && start_edge_s && !seq.abort) begin
      mask_r <= seq.phase_mask;
      rep_r  <= (seq.n_repeat == {REPEAT_W{1'b0}}) ? REPEAT_W'(1) : seq.n_repeat;
      iter_r <= {REPEAT_W{1'b0}};
      terr_r <= 1'b0;
    end else if ((state_next == S_ERROR) && (state_r != S_ERROR)) begin
      terr_r      <= 1'b1;
      err_phase_r <= phase_code(state_r);
    end else if ((state_r == S_NEXT) && !seq.abort && (iter_r != {REPEAT_W{1'b1}})) begin
      iter_r <= iter_r + REPEAT_W'(1);
    end else begin
      iter_r <= iter_r;
    end
  end

  // Dwell counters: both restart whenever the state changes.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      to_cnt_r  <= {TO_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      if (is_waiting(state_r) && (state_next == state_r)) to_cnt_r <= to_cnt_r + TO_W'(1);
      else                                                to_cnt_r <= {TO_W{1'b0}};
      if ((state_r == S_GAP) && (state_next == S_GAP))    gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      else                                                gap_cnt_r <= {GAP_W{1'b0}};
    end
  end

  // Output flops load the decode of the next state, so they track state_r exactly.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      osc_r   <= 1'b0;
      rx_r    <= 1'b0;
      tx_r    <= 1'b0;
      adv_r   <= 1'b0;
      ew_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      phase_r <= 3'd0;
    end else begin
      osc_r   <= (state_next == S_TRIM);
      rx_r    <= (state_next == S_RX);
      tx_r    <= (state_next == S_TX);
      adv_r   <= (state_next == S_CUSTOM);
      ew_r    <= (state_next == S_ENDWAIT);
      busy_r  <= (state_next != S_IDLE) && (state_next != S_DONE) && (state_next != S_ERROR);
      done_r  <= (state_next == S_DONE);
      phase_r <= phase_code(state_next);
    end
  end

  assign seq.osc_auto_trim = osc_r;
  assign seq.test_rx       = rx_r;
  assign seq.test_tx       = tx_r;
  assign seq.test_advanced = adv_r;
  assign seq.endwait_all   = ew_r;
  assign seq.phase         = phase_r;
  assign seq.iter_cnt      = iter_r;
  assign seq.busy          = busy_r;
  assign seq.done          = done_r;
  assign seq.timeout_err   = terr_r;
  assign seq.err_phase     = err_phase_r;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Directed bench for mopshub_test_sequencer: a segment-queue model predicts every
// output each cycle, plus hand-computed latency and count checks per scenario.
module tb_mopshub_test_sequencer;
  localparam int G  = 120;
  localparam int T  = 64;
  localparam int RW = 8;
  localparam int K_TRIM = 1, K_RX = 2, K_EW = 3, K_GAP = 4, K_TX = 5, K_CUS = 6, K_NEXT = 7, K_DONE = 8;

  logic clk_40_m = 1'b0;
  logic rst      = 1'b0;
  always #5 clk_40_m = ~clk_40_m;

  mopshub_test_sequencer_if #(.REPEAT_W(RW)) seq ();
  mopshub_test_sequencer #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .REPEAT_W(RW)) dut (
    .clk_40_m(clk_40_m), .rst(rst), .seq(seq)
  );

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: the run is a queue of segments; the head segment is what the DUT should show.
  int plan[$];
  int dwell = 0, m_errph = 0, m_iter = 0;
  bit m_err = 1'b0, m_tout = 1'b0, s1 = 1'b0, s2 = 1'b0;

  function automatic int code_of(input int k);
    case (k)
      K_TRIM: return 1;
      K_RX: return 2;
      K_EW, K_GAP: return 3;
      K_TX: return 4;
      K_CUS: return 5;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk_40_m) begin : model_blk
    bit edge_seen;
    bit end_in;
    int head;
    int reps;
    edge_seen = s1 && !s2;
    s2 = s1;
    s1 = seq.start;
    if (!rst) begin
      plan.delete(); dwell = 0; m_err = 0; m_errph = 0; m_iter = 0; m_tout = 0; s1 = 0; s2 = 0;
    end else if (seq.abort) begin
      plan.delete(); dwell = 0; m_err = 0;
    end else if (m_err) begin
      dwell = 0;
    end else if (plan.size() == 0) begin
      if (edge_seen) begin
        reps = (seq.n_repeat == 0) ? 1 : int'(seq.n_repeat);
        if (seq.phase_mask == 4'b0000) plan.push_back(K_DONE);
        else begin
          for (int r = 0; r < reps; r++) begin
            if (seq.phase_mask[0]) plan.push_back(K_TRIM);
            if (seq.phase_mask[1]) begin plan.push_back(K_RX); plan.push_back(K_EW); plan.push_back(K_GAP); end
            if (seq.phase_mask[2]) plan.push_back(K_TX);
            if (seq.phase_mask[3]) plan.push_back(K_CUS);
            plan.push_back(K_NEXT);
          end
          plan.push_back(K_DONE);
        end
        m_iter = 0; m_tout = 0; dwell = 0;
      end
    end else begin
      head = plan[0];
      case (head)
        K_TRIM, K_RX, K_TX, K_CUS: begin
          end_in = (head == K_TRIM) ? seq.trim_done : (head == K_RX) ? seq.rx_end :
                   (head == K_TX) ? seq.tx_end : seq.custom_end;
          if (end_in) begin void'(plan.pop_front()); dwell = 0; end
          else if (dwell == T - 1) begin
            m_err = 1; m_tout = 1; m_errph = code_of(head); plan.delete(); dwell = 0;
          end else dwell++;
        end
        K_GAP: begin
          if (dwell == G - 1) begin void'(plan.pop_front()); dwell = 0; end
          else dwell++;
        end
        K_NEXT: begin
          if (m_iter < 255) m_iter++;
          void'(plan.pop_front()); dwell = 0;
        end
        default: begin void'(plan.pop_front()); dwell = 0; end
      endcase
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk_40_m) begin : cmp_blk
    int h;
    if (check_en) begin
      h = (plan.size() > 0 && !m_err) ? plan[0] : 0;
      chk("osc_auto_trim", int'(seq.osc_auto_trim), int'(h == K_TRIM));
      chk("test_rx", int'(seq.test_rx), int'(h == K_RX));
      chk("test_tx", int'(seq.test_tx), int'(h == K_TX));
      chk("test_advanced", int'(seq.test_advanced), int'(h == K_CUS));
      chk("endwait_all", int'(seq.endwait_all), int'(h == K_EW));
      chk("busy", int'(seq.busy), int'(h >= K_TRIM && h <= K_NEXT));
      chk("done", int'(seq.done), int'(h == K_DONE));
      chk("phase", int'(seq.phase), m_err ? 6 : code_of(h));
      chk("iter_cnt", int'(seq.iter_cnt), m_iter);
      chk("timeout_err", int'(seq.timeout_err), int'(m_tout));
      chk("err_phase", int'(seq.err_phase), m_errph);
    end
  end

  int done_n = 0, ew_n = 0, tx_rise = 0, adv_rise = 0;
  bit tx_prev = 1'b0, adv_prev = 1'b0;
  always @(negedge clk_40_m) begin
    if (seq.done) done_n++;
    if (seq.endwait_all) ew_n++;
    if (seq.test_tx && !tx_prev) tx_rise++;
    if (seq.test_advanced && !adv_prev) adv_rise++;
    tx_prev = seq.test_tx;
    adv_prev = seq.test_advanced;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_40_m);
  endtask

  function automatic bit out_sel(input int s);
    case (s)
      0: return seq.osc_auto_trim;
      1: return seq.test_rx;
      2: return seq.test_tx;
      3: return seq.test_advanced;
      4: return seq.endwait_all;
      5: return seq.done;
      6: return seq.phase == 3'd6;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int s, input int budget, output int cycles);
    cycles = 0;
    while (!out_sel(s) && cycles < budget) begin
      @(negedge clk_40_m);
      cycles++;
    end
    if (!out_sel(s)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_sel%0d: got 0 after %0d cycles, expected 1", s, budget);
    end
  endtask

  task automatic set_end(input int s, input logic v);
    case (s)
      0: seq.trim_done = v;
      1: seq.rx_end = v;
      2: seq.tx_end = v;
      default: seq.custom_end = v;
    endcase
  endtask

  task automatic serve(input int s, input int delay);
    int c;
    wait_for(s, 400, c);
    tick(delay);
    set_end(s, 1'b1);
    tick(1);
    set_end(s, 1'b0);
  endtask

  task automatic do_start(input logic [3:0] m, input logic [RW-1:0] r);
    seq.phase_mask = m;
    seq.n_repeat = r;
    seq.start = 1'b1;
    tick(1);
    seq.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c, d0, t0, e0, a0;
    seq.start = 0; seq.abort = 0; seq.phase_mask = 4'b0000; seq.n_repeat = '0;
    seq.trim_done = 0; seq.rx_end = 0; seq.tx_end = 0; seq.custom_end = 0;
    tick(3);
    check_en = 1'b1;
    chk("rst_phase", int'(seq.phase), 0);
    chk("rst_busy", int'(seq.busy), 0);
    rst = 1'b1;
    tick(2);

    // 1: full sequence
    d0 = done_n;
    do_start(4'b1111, 8'd1);
    serve(0, 9);
    serve(1, 9);
    wait_for(4, 20, c);
    wait_for(2, 300, c);
    chk("t1_ew_to_tx", c, G + 1);
    serve(2, 9);
    serve(3, 9);
    wait_for(5, 20, c);
    chk("t1_done_lat", c, 1);
    chk("t1_iter", int'(seq.iter_cnt), 1);
    chk("t1_model_iter", m_iter, 1);
    tick(3);
    chk("t1_done_pulses", done_n - d0, 1);

    // 2: TX only, three iterations
    d0 = done_n; t0 = tx_rise; e0 = ew_n;
    do_start(4'b0100, 8'd3);
    repeat (3) serve(2, 9);
    wait_for(5, 20, c);
    tick(3);
    chk("t2_iter", int'(seq.iter_cnt), 3);
    chk("t2_done_pulses", done_n - d0, 1);
    chk("t2_tx_windows", tx_rise - t0, 3);
    chk("t2_endwait", ew_n - e0, 0);

    // 3: RX timeout, start ignored in ERROR, abort recovers
    do_start(4'b0010, 8'd1);
    wait_for(1, 20, c);
    wait_for(6, 200, c);
    chk("t3_timeout_lat", c, T);
    chk("t3_timeout_err", int'(seq.timeout_err), 1);
    chk("t3_err_phase", int'(seq.err_phase), 2);
    chk("t3_test_rx", int'(seq.test_rx), 0);
    do_start(4'b1111, 8'd1);
    tick(5);
    chk("t3_start_ignored", int'(seq.phase), 6);
    seq.abort = 1'b1;
    tick(1);
    seq.abort = 1'b0;
    chk("t3_abort_phase", int'(seq.phase), 0);
    chk("t3_err_sticky", int'(seq.timeout_err), 1);
    tick(2);

    // 4: tx_end on the last timeout cycle wins
    do_start(4'b0100, 8'd1);
    wait_for(2, 20, c);
    tick(T - 1);
    seq.tx_end = 1'b1;
    tick(1);
    seq.tx_end = 1'b0;
    chk("t4_no_error", int'(seq.timeout_err), 0);
    chk("t4_phase", int'(seq.phase), 0);
    wait_for(5, 20, c);
    tick(2);

    // 5: abort during GAP, then reset during TX
    d0 = done_n; t0 = tx_rise;
    do_start(4'b0110, 8'd1);
    serve(1, 9);
    wait_for(4, 20, c);
    tick(5);
    seq.abort = 1'b1;
    tick(1);
    seq.abort = 1'b0;
    chk("t5_abort_phase", int'(seq.phase), 0);
    chk("t5_abort_busy", int'(seq.busy), 0);
    tick(150);
    chk("t5_no_done", done_n - d0, 0);
    chk("t5_no_tx", tx_rise - t0, 0);
    do_start(4'b0110, 8'd1);
    serve(1, 9);
    wait_for(2, 300, c);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("t5_rst_tx", int'(seq.test_tx), 0);
    chk("t5_rst_phase", int'(seq.phase), 0);
    chk("t5_rst_busy", int'(seq.busy), 0);
    chk("t5_rst_iter", int'(seq.iter_cnt), 0);
    rst = 1'b1;
    tick(2);

    // 6: corner inputs
    seq.phase_mask = 4'b0000;
    seq.n_repeat = 8'd1;
    seq.start = 1'b1;
    wait_for(5, 10, c);
    seq.start = 1'b0;
    chk("t6_mask0_lat", c, 2);
    chk("t6_mask0_iter", int'(seq.iter_cnt), 0);
    tick(3);
    t0 = tx_rise;
    do_start(4'b0100, 8'd0);
    serve(2, 9);
    wait_for(5, 20, c);
    chk("t6_rep0_iter", int'(seq.iter_cnt), 1);
    tick(3);
    chk("t6_rep0_tx", tx_rise - t0, 1);
    d0 = done_n; a0 = adv_rise;
    seq.phase_mask = 4'b1000;
    seq.n_repeat = 8'd1;
    seq.start = 1'b1;
    serve(3, 9);
    wait_for(5, 20, c);
    tick(40);
    chk("t6_held_runs", adv_rise - a0, 1);
    chk("t6_held_done", done_n - d0, 1);
    seq.start = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
